// File: rtl/seed_hit_array.sv
// Systolic seed-hit detector: NUM_CELLS query cells compare one broadcast subject
// nucleotide per cycle, track diagonal match runs and queue exact word hits for output.
module seed_hit_array #(
    parameter int LENGTH_CHAR    = 3,
    parameter int LENGTH_COUNTER = 8,
    parameter int LENGTH_ADDRESS = 16,
    parameter int NUM_CELLS      = 16,
    parameter int WORD_LEN       = 4
) (
    input  logic                      com_clk,
    input  logic                      reset,
    input  logic                      query_clear,
    input  logic                      query_valid,
    input  logic [LENGTH_CHAR-1:0]    query_char,
    output logic                      query_ready,
    output logic                      query_full,
    input  logic                      sub_start,
    input  logic                      sub_valid,
    input  logic [LENGTH_CHAR-1:0]    sub_char,
    output logic                      sub_ready,
    output logic                      hit_valid,
    input  logic                      hit_ready,
    output logic [LENGTH_COUNTER-1:0] hit_query_id,
    output logic [LENGTH_ADDRESS-1:0] hit_sub_id,
    output logic [LENGTH_ADDRESS-1:0] sub_count
);

    localparam int QW = $clog2(NUM_CELLS + 1);
    localparam int RW = $clog2(WORD_LEN + 1);
    localparam logic [RW-1:0]          RUN_MAX = RW'(WORD_LEN);
    localparam logic [LENGTH_CHAR-1:0] CODE_N  = LENGTH_CHAR'(5);
    localparam logic [LENGTH_ADDRESS-1:0] BASE_OFS = LENGTH_ADDRESS'(WORD_LEN - 1);
    localparam logic [LENGTH_COUNTER-1:0] QID_OFS  = LENGTH_COUNTER'(WORD_LEN - 1);

    logic [LENGTH_CHAR-1:0]    r_cell [NUM_CELLS];
    logic [RW-1:0]             r_run  [NUM_CELLS];
    logic [QW-1:0]             r_q_count;
    logic [NUM_CELLS-1:0]      r_pend;
    logic [LENGTH_ADDRESS-1:0] r_hit_base;
    logic [LENGTH_ADDRESS-1:0] r_sub_count;

    logic                      w_query_code_ok;
    logic                      w_sub_code_ok;
    logic                      w_query_full;
    logic                      w_query_load;
    logic                      w_pend_single;
    logic                      w_sub_acc;
    logic                      w_sub_take;
    logic                      w_hit_take;
    logic                      w_flush;
    logic [NUM_CELLS-1:0]      w_match;
    logic [NUM_CELLS-1:0]      w_new_hit;
    logic [NUM_CELLS-1:0]      w_pend_next;
    logic [RW-1:0]             w_run_prev [NUM_CELLS];
    logic [RW-1:0]             w_run_ext  [NUM_CELLS];
    logic [RW-1:0]             w_run_next [NUM_CELLS];
    logic [LENGTH_CHAR-1:0]    w_cell_next [NUM_CELLS];
    logic [LENGTH_COUNTER-1:0] w_low_idx;

    assign w_query_code_ok = (query_char != '0) && (query_char <= CODE_N);
    assign w_sub_code_ok   = (sub_char != '0) && (sub_char <= CODE_N);
    assign w_query_full    = (r_q_count == QW'(NUM_CELLS));
    assign w_query_load    = query_valid && !w_query_full && w_query_code_ok;
    assign w_flush         = query_clear || sub_start;

    // Subject may only advance when at most one hit is left and it leaves this cycle.
    assign w_pend_single = (r_pend != '0) && ((r_pend & (r_pend - 1'b1)) == '0);
    assign sub_ready     = w_query_full && !w_flush &&
                           ((r_pend == '0) || (w_pend_single && hit_ready));
    assign w_sub_acc     = sub_valid && sub_ready;
    assign w_sub_take    = w_sub_acc && w_sub_code_ok;
    assign w_hit_take    = hit_valid && hit_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            if (gi == 0) begin : g_first
                assign w_run_prev[gi] = '0;
            end else begin : g_rest
                assign w_run_prev[gi] = r_run[gi-1];
            end
            assign w_match[gi]     = (r_cell[gi] == sub_char) && (sub_char != CODE_N) &&
                                     (r_cell[gi] != CODE_N);
            assign w_run_ext[gi]   = (w_run_prev[gi] == RUN_MAX) ? RUN_MAX
                                                                 : w_run_prev[gi] + RW'(1);
            assign w_run_next[gi]  = w_match[gi] ? w_run_ext[gi] : '0;
            assign w_new_hit[gi]   = w_match[gi] && (w_run_ext[gi] == RUN_MAX);
            assign w_cell_next[gi] = (w_query_load && (r_q_count == QW'(gi))) ? query_char
                                                                              : r_cell[gi];
        end
    endgenerate

    // A fresh subject char overwrites P: it was empty or its single bit is draining now.
    always_comb begin
        w_pend_next = r_pend;
        if (w_sub_take) begin
            w_pend_next = w_new_hit;
        end else if (w_hit_take) begin
            w_pend_next = r_pend & (r_pend - 1'b1);
        end
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = LENGTH_COUNTER'(i);
            end
        end
    end

    always_ff @(posedge com_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_cell[i] <= '0;
                r_run[i]  <= '0;
            end
            r_q_count   <= '0;
            r_pend      <= '0;
            r_hit_base  <= '0;
            r_sub_count <= '0;
        end else begin
            if (query_clear) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    r_cell[i] <= '0;
                end
                r_q_count <= '0;
            end else if (w_query_load) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    r_cell[i] <= w_cell_next[i];
                end
                r_q_count <= r_q_count + QW'(1);
            end

            if (w_flush) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    r_run[i] <= '0;
                end
                r_pend      <= '0;
                r_hit_base  <= '0;
                r_sub_count <= '0;
            end else begin
                if (w_sub_take) begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        r_run[i] <= w_run_next[i];
                    end
                    r_hit_base  <= r_sub_count - BASE_OFS;
                    r_sub_count <= r_sub_count + LENGTH_ADDRESS'(1);
                end
                r_pend <= w_pend_next;
            end
        end
    end

    assign query_full   = w_query_full;
    assign query_ready  = !w_query_full;
    assign hit_valid    = (r_pend != '0);
    assign hit_query_id = hit_valid ? (w_low_idx - QID_OFS) : '0;
    assign hit_sub_id   = r_hit_base;
    assign sub_count    = r_sub_count;

endmodule

// File: tb/tb_seed_hit_array.sv
// Directed bench for seed_hit_array (8 cells, word length 4): query load, hit ordering,
// backpressure, invalid/N codes, restart and asynchronous reset.
module tb_seed_hit_array;

    localparam int LC  = 3;
    localparam int LQ  = 8;
    localparam int LA  = 16;
    localparam int NC  = 8;
    localparam int WL  = 4;

    localparam logic [2:0] A = 3'd1;
    localparam logic [2:0] G = 3'd2;
    localparam logic [2:0] T = 3'd3;
    localparam logic [2:0] C = 3'd4;
    localparam logic [2:0] N = 3'd5;

    logic          clk = 1'b0;
    logic          rst;
    logic          query_clear;
    logic          query_valid;
    logic [LC-1:0] query_char;
    logic          query_ready;
    logic          query_full;
    logic          sub_start;
    logic          sub_valid;
    logic [LC-1:0] sub_char;
    logic          sub_ready;
    logic          hit_valid;
    logic          hit_ready;
    logic [LQ-1:0] hit_query_id;
    logic [LA-1:0] hit_sub_id;
    logic [LA-1:0] sub_count;

    int checks = 0;
    int errors = 0;

    logic [2:0] q_agtc [8];
    logic [2:0] q_aaaa [8];

    seed_hit_array #(
        .LENGTH_CHAR(LC), .LENGTH_COUNTER(LQ), .LENGTH_ADDRESS(LA),
        .NUM_CELLS(NC), .WORD_LEN(WL)
    ) dut (
        .com_clk(clk), .reset(rst),
        .query_clear(query_clear), .query_valid(query_valid), .query_char(query_char),
        .query_ready(query_ready), .query_full(query_full),
        .sub_start(sub_start), .sub_valid(sub_valid), .sub_char(sub_char),
        .sub_ready(sub_ready), .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_query_id(hit_query_id), .hit_sub_id(hit_sub_id), .sub_count(sub_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [2:0] s [8]);
        for (int i = 0; i < 8; i++) begin
            query_valid = 1'b1;
            query_char  = s[i];
            tick();
        end
        query_valid = 1'b0;
    endtask

    task automatic send_sub(input logic [2:0] ch);
        sub_valid = 1'b1;
        sub_char  = ch;
        tick();
        sub_valid = 1'b0;
    endtask

    task automatic check_hit(input string tag, input logic [31:0] q, input logic [31:0] s);
        check({tag, "_valid"}, hit_valid, 1);
        check({tag, "_qid"}, hit_query_id, q);
        check({tag, "_sid"}, hit_sub_id, s);
    endtask

    initial begin
        q_agtc = '{A, G, T, C, A, G, T, C};
        q_aaaa = '{A, A, A, A, A, A, A, A};
        rst = 1'b1; query_clear = 1'b0; query_valid = 1'b0; query_char = '0;
        sub_start = 1'b0; sub_valid = 1'b0; sub_char = '0; hit_ready = 1'b1;

        // Reset state
        #2;
        check("rst_query_ready", query_ready, 1);
        check("rst_query_full", query_full, 0);
        check("rst_sub_ready", sub_ready, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_sub_count", sub_count, 0);
        check("rst_hit_qid", hit_query_id, 0);
        check("rst_hit_sid", hit_sub_id, 0);
        tick();
        rst = 1'b0;

        // Query load with an invalid code interleaved, then overflow
        for (int i = 0; i < 3; i++) begin
            query_valid = 1'b1; query_char = q_agtc[i]; tick();
        end
        query_char = 3'd7; tick();
        for (int i = 3; i < 7; i++) begin
            query_char = q_agtc[i]; tick();
        end
        check("load7_full", query_full, 0);
        check("load7_sub_ready", sub_ready, 0);
        query_char = q_agtc[7]; tick();
        check("load8_full", query_full, 1);
        query_char = A; tick();
        query_char = A; tick();
        query_valid = 1'b0;
        check("ovf_full", query_full, 1);
        check("ovf_ready", query_ready, 0);
        check("ovf_sub_ready", sub_ready, 1);

        // Overlapping hits with single-cycle backpressure
        send_sub(A); send_sub(G); send_sub(T);
        check("ov_pre_hit", hit_valid, 0);
        check("ov_pre_cnt", sub_count, 3);
        send_sub(C);
        check_hit("ov_h0", 0, 0);
        check("ov_h0_sub_ready", sub_ready, 0);
        check("ov_cnt", sub_count, 4);
        tick();
        check_hit("ov_h1", 4, 0);
        check("ov_h1_sub_ready", sub_ready, 1);
        tick();
        check("ov_done", hit_valid, 0);
        check("ov_done_sub_ready", sub_ready, 1);

        // Saturated extension on an all-A query
        query_clear = 1'b1; tick(); query_clear = 1'b0;
        check("clr_full", query_full, 0);
        check("clr_cnt", sub_count, 0);
        load8(q_aaaa);
        sub_valid = 1'b1; sub_char = A;
        for (int k = 0; k < 4; k++) tick();
        for (int j = 0; j < 5; j++) begin
            check_hit($sformatf("sat0_h%0d", j), j, 0);
            check($sformatf("sat0_rdy%0d", j), sub_ready, (j == 4) ? 1 : 0);
            tick();
        end
        sub_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check_hit($sformatf("sat1_h%0d", j), j, 1);
            check($sformatf("sat1_rdy%0d", j), sub_ready, (j == 4) ? 1 : 0);
            tick();
        end
        check("sat_done", hit_valid, 0);
        check("sat_cnt", sub_count, 5);

        // N breaks a run; code 7 is discarded without disturbing runs
        query_clear = 1'b1; tick(); query_clear = 1'b0;
        load8(q_agtc);
        send_sub(A); send_sub(G); send_sub(N); send_sub(T); send_sub(C);
        check("n_no_hit", hit_valid, 0);
        check("n_cnt", sub_count, 5);
        sub_start = 1'b1; tick(); sub_start = 1'b0;
        check("ss_cnt", sub_count, 0);
        send_sub(A); send_sub(G);
        sub_valid = 1'b1; sub_char = 3'd7;
        check("c7_ready", sub_ready, 1);
        tick(); sub_valid = 1'b0;
        check("c7_cnt", sub_count, 2);
        check("c7_hit", hit_valid, 0);
        send_sub(T); send_sub(C);
        check_hit("c7_h0", 0, 0);
        tick();
        check_hit("c7_h1", 4, 0);
        tick();
        check("c7_done", hit_valid, 0);
        check("c7_cnt_end", sub_count, 4);

        // Hit backpressure, then restart via sub_start
        hit_ready = 1'b0;
        sub_start = 1'b1; tick(); sub_start = 1'b0;
        send_sub(A); send_sub(G); send_sub(T); send_sub(C);
        check_hit("bp_h0", 0, 0);
        check("bp_rdy0", sub_ready, 0);
        sub_valid = 1'b1; sub_char = A;
        tick(); tick();
        sub_valid = 1'b0;
        check_hit("bp_hold", 0, 0);
        check("bp_rdy_hold", sub_ready, 0);
        check("bp_cnt_hold", sub_count, 4);
        sub_start = 1'b1; tick(); sub_start = 1'b0;
        check("rs_hit", hit_valid, 0);
        check("rs_cnt", sub_count, 0);
        sub_start = 1'b1; sub_valid = 1'b1; sub_char = A;
        #1;
        check("ss_force_rdy", sub_ready, 0);
        tick();
        sub_start = 1'b0; sub_valid = 1'b0;
        check("ss_drop_cnt", sub_count, 0);

        // Asynchronous reset with a hit pending
        send_sub(A); send_sub(G); send_sub(T); send_sub(C);
        check("ar_pre_hit", hit_valid, 1);
        check("ar_pre_cnt", sub_count, 4);
        #2;
        rst = 1'b1;
        #1;
        check("ar_hit", hit_valid, 0);
        check("ar_full", query_full, 0);
        check("ar_qready", query_ready, 1);
        check("ar_cnt", sub_count, 0);
        check("ar_sub_ready", sub_ready, 0);
        check("ar_qid", hit_query_id, 0);
        tick();
        rst = 1'b0;
        hit_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seed_hit_array.md
Name: seed_hit_array

Overview:
- Parametrised successor to the single-cell query/subject comparator: `NUM_CELLS` query cells compare one broadcast subject nucleotide per cycle.
- Per-cell diagonal run counters track consecutive matches; a hit is reported when a run reaches `WORD_LEN` (an exact word hit).
- Hits are queued and emitted one per cycle over a valid/ready interface to the downstream extension stage.
- Sits between the nucleotide stream front-end and the ungapped-extension logic of the BLAST accelerator.

Parameters:
- `LENGTH_CHAR`, 3, nucleotide code width (A=1, G=2, T=3, C=4, N=5).
- `LENGTH_COUNTER`, 8, query index width; requires NUM_CELLS <= 2^LENGTH_COUNTER.
- `LENGTH_ADDRESS`, 16, subject index width; wraps modulo 2^LENGTH_ADDRESS.
- `NUM_CELLS`, 16, number of query cells (maximum query length).
- `WORD_LEN`, 4, word length for a hit; 1 <= WORD_LEN <= NUM_CELLS.

Ports:
- `com_clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `query_clear`  in  1  sync pulse: empty query cells, clear all subject/run/hit state.
- `query_valid`  in  1  query char offered.
- `query_char`  in  LENGTH_CHAR  query nucleotide.
- `query_ready`  out  1  = !query_full.
- `query_full`  out  1  all NUM_CELLS loaded.
- `sub_start`  in  1  sync pulse: new subject; clear sub index, runs, pending hits.
- `sub_valid`  in  1  subject char offered.
- `sub_char`  in  LENGTH_CHAR  subject nucleotide.
- `sub_ready`  out  1  subject char accepted when sub_valid & sub_ready.
- `hit_valid`  out  1  hit available.
- `hit_ready`  in  1  downstream accepts hit.
- `hit_query_id`  out  LENGTH_COUNTER  query start index of word.
- `hit_sub_id`  out  LENGTH_ADDRESS  subject start index of word.
- `sub_count`  out  LENGTH_ADDRESS  number of subject chars accepted since sub_start.

Behaviour:
- **Reset:** all outputs 0 except query_ready=1. Cells empty, query count 0, runs 0, pending vector P=0, sub index 0. An async reset mid-stream discards everything, including pending hits.
- **Valid codes:** 1..5. Codes 0, 6 and 7 are consumed when handshaken but discarded: no count or id change, runs untouched.
- **Query load:** on a query_valid & query_ready cycle with a valid code, cell[q_count] <= char and q_count++. query_full=1 when q_count==NUM_CELLS. Further query chars are ignored (query_ready=0).
- **Subject gating:** sub_ready=0 while !query_full.
- **Backpressure:** otherwise sub_ready = (P==0) | (P has exactly one bit set & hit_ready).
- **Match rule:** on accepted valid subject char s at index k=sub_count: m[i] = (cell[i]==s) & (s!=N) & (cell[i]!=N).
- **Run update:** run[i] <= m[i] ? min(run[i-1]+1, WORD_LEN) : 0, with run[-1]=0, using old run values. Counter width is clog2(WORD_LEN+1).
- **Hit set:** new run[i]==WORD_LEN sets P[i] next cycle. P captures k-WORD_LEN+1 (mod 2^LENGTH_ADDRESS) as the hit sub base. sub_count++.
- **Hit output:** hit_valid = (P!=0). hit_query_id = index of lowest set bit of P minus (WORD_LEN-1). hit_sub_id = captured sub base.
- **Hit drain:** on hit_valid & hit_ready the lowest bit of P is cleared. If a new subject char is accepted in the same cycle, its hits replace P, since P was single-bit and drained.
- **Hit latency:** 1 cycle from subject acceptance to hit_valid.
- **Multiple hits:** emitted in ascending query index, one per cycle. Subject input is stalled until the last hit is being taken.
- **Runs at a non-accepting cycle:** unchanged. Extended runs stay saturated, so every overlapping word position produces its own hit.
- **sub_start:** clears runs, P, sub_count. Takes priority over a same-cycle subject accept, which is dropped and sub_ready is forced 0 that cycle.
- **query_clear:** does everything sub_start does, plus empties cells. Highest priority.
- **sub_count wrap:** wraps to 0 after 2^LENGTH_ADDRESS-1. hit_sub_id is computed modulo.

Test Plan:
- **Load overflow:** NUM_CELLS=8, WORD_LEN=4; load "AGTCAGTC" then offer 2 more chars → query_full=1, query_ready=0, extra chars ignored, cells unchanged.
- **Overlapping hits, single backpressure:** query "AGTCAGTC", subject "AGTC", hit_ready=1.
  - After the 'C' (k=3): hits (query 0, sub 0) then (query 4, sub 0) on consecutive cycles.
  - sub_ready=0 for exactly one cycle.
- **Saturated extension:** query "AAAAAAAA", subject "AAAAA" → subject k=3 yields 5 hits (q 0..4, sub 0); k=4 yields 5 hits (q 0..4, sub 1); total 10, in ascending q order.
- **N and invalid codes:** subject "AGNTC" against query "AGTC…" → no hit (N breaks the run). Code 7 mid-stream leaves sub_count and runs unchanged.
- **Hit backpressure and restart:** hold hit_ready=0 with a pending hit → hit_valid and ids stable, sub_ready=0. sub_start then clears P: hit_valid=0, sub_count=0.
- **Async reset mid-stream:** assert reset asynchronously mid-stream → outputs clear immediately without a clock edge, query_full=0, query_ready=1.
